mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-memory req/ack access with timeout, MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them.
module mem_stage #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [WORD_SIZE-1:0] ex_result,
    input  logic [WORD_SIZE-1:0] ex_write_data,
    input  logic [REG_SEL-1:0]   ex_rd,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic [1:0]           ex_mem_size,
    input  logic                 ex_mem_unsigned,
    output logic                 stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [WORD_SIZE-1:0] dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [WORD_SIZE-1:0] dmem_rdata,
    output logic [WORD_SIZE-1:0] mem_forward,
    output logic                 wb_valid,
    output logic [REG_SEL-1:0]   wb_rd,
    output logic                 wb_reg_write,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic                 bus_err,
    output logic                 misalign_trap
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef struct packed {
        logic                 valid;
        logic [WORD_SIZE-1:0] result;
        logic [WORD_SIZE-1:0] wdata;
        logic [REG_SEL-1:0]   rd;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic [1:0]           size;
        logic                 uns;
    } exmem_t;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t               state, next_state;
    exmem_t               r;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 in_access, timeout_hit, tmo_err, ex_mem_op, r_trap;
    logic [1:0]           off, eff_off;
    logic [3:0]           be_raw;
    logic [WORD_SIZE-1:0] wdata_rep, shifted, load_data;

    assign in_access   = (state == ACCESS);
    assign timeout_hit = in_access && (wait_cnt == TMO);
    // An ack arriving on the timeout cycle still completes normally.
    assign tmo_err     = timeout_hit && !dmem_ack;
    assign stall       = in_access && !dmem_ack && !timeout_hit;
    assign off         = r.result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    logic ex_misalign;
    assign ex_misalign = (ex_mem_size == 2'b01 && ex_result[0]) ||
                         (ex_mem_size[1] && ex_result[1:0] != 2'b00);
    assign ex_mem_op   = ex_valid && (ex_mem_read || ex_mem_write) && !ex_misalign;
    assign r_trap      = r.valid && (r.mem_read || r.mem_write) &&
                         ((r.size == 2'b01 && off[0]) || (r.size[1] && off != 2'b00));
`else
    assign ex_mem_op   = ex_valid && (ex_mem_read || ex_mem_write);
    assign r_trap      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!stall) next_state = ex_mem_op ? ACCESS : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !stall) wait_cnt <= '0;
        else                  wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r <= '0;
        end else if (!stall) begin
            r.valid     <= ex_valid;
            r.result    <= ex_result;
            r.wdata     <= ex_write_data;
            r.rd        <= ex_rd;
            r.reg_write <= ex_reg_write;
            r.mem_read  <= ex_mem_read;
            r.mem_write <= ex_mem_write;
            r.size      <= ex_mem_size;
            r.uns       <= ex_mem_unsigned;
        end
    end

    // Half/word offsets are forced to natural alignment; with the trap build
    // misaligned accesses never reach the bus so this only matters otherwise.
    always_comb begin
        eff_off   = 2'b00;
        be_raw    = 4'b1111;
        wdata_rep = r.wdata;
        case (r.size)
            2'b00: begin
                eff_off   = off;
                be_raw    = 4'b0001 << off;
                wdata_rep = {4{r.wdata[7:0]}};
            end
            2'b01: begin
                eff_off   = {off[1], 1'b0};
                be_raw    = 4'b0011 << eff_off;
                wdata_rep = {2{r.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = dmem_rdata >> {eff_off, 3'b000};
        load_data = shifted;
        case (r.size)
            2'b00:   load_data = {{(WORD_SIZE-8){!r.uns && shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{(WORD_SIZE-16){!r.uns && shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    assign dmem_req    = in_access;
    assign dmem_we     = in_access && r.mem_write;
    assign dmem_addr   = in_access ? r.result[ADDR_SIZE+1:2] : '0;
    assign dmem_be     = in_access ? be_raw : 4'b0000;
    assign dmem_wdata  = in_access ? wdata_rep : '0;
    assign mem_forward = r.result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            bus_err       <= 1'b0;
            misalign_trap <= 1'b0;
        end else if (!stall) begin
            wb_valid      <= r.valid;
            wb_rd         <= r.rd;
            wb_data       <= r.mem_read ? load_data : r.result;
            bus_err       <= r.valid && tmo_err;
            misalign_trap <= r_trap;
            wb_reg_write  <= r.valid && r.reg_write && !r.mem_write && !tmo_err && !r_trap;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table driven through a cycle-level memory responder,
// retirements checked against a scoreboard queue, plus back-to-back / stray-ack / reset corners.
module tb_mem_stage;

    logic        clk, rst_n;
    logic        ex_valid;
    logic [31:0] ex_result, ex_write_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_unsigned;
    logic [1:0]  ex_mem_size;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [9:0]  dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata, mem_forward, wb_data;
    logic        wb_valid, wb_reg_write, bus_err, misalign_trap;
    logic [4:0]  wb_rd;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_write_data(ex_write_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_forward(mem_forward), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data), .bus_err(bus_err),
        .misalign_trap(misalign_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd_op, wr_op;
        logic [1:0]  size;
        logic        uns, reg_wr;
        logic [31:0] result, wdata;
        logic [4:0]  rd;
        int          ack_dly;
        logic [31:0] rdata;
        logic        exp_req;
        logic [9:0]  exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_stall;
        logic [31:0] exp_data;
        logic        chk_data, exp_we, exp_err, exp_trap;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data, we, err, trap;
    } exp_t;

    int    n_chk = 0;
    int    n_fail = 0;
    exp_t  sb_q[$];
    exp_t  mon_e;
    vec_t  vecs[$];
    logic  w_load = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(input string name, input logic rd_op, input logic wr_op,
                                input logic [1:0] size, input logic uns, input logic reg_wr,
                                input logic [31:0] result, input logic [31:0] wdata,
                                input logic [4:0] rd, input int ack_dly, input logic [31:0] rdata,
                                input logic exp_req, input logic [9:0] exp_addr,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                input int exp_stall, input logic [31:0] exp_data,
                                input logic chk_data, input logic exp_we, input logic exp_err,
                                input logic exp_trap);
        vec_t v;
        v.name = name; v.rd_op = rd_op; v.wr_op = wr_op; v.size = size; v.uns = uns;
        v.reg_wr = reg_wr; v.result = result; v.wdata = wdata; v.rd = rd;
        v.ack_dly = ack_dly; v.rdata = rdata; v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_stall = exp_stall;
        v.exp_data = exp_data; v.chk_data = chk_data; v.exp_we = exp_we;
        v.exp_err = exp_err; v.exp_trap = exp_trap;
        return v;
    endfunction

    task automatic push_exp(input string name, input logic [4:0] rd, input logic [31:0] data,
                            input logic chk_data, input logic we, input logic err, input logic trap);
        exp_t e;
        e.name = name; e.rd = rd; e.data = data; e.chk_data = chk_data;
        e.we = we; e.err = err; e.trap = trap;
        sb_q.push_back(e);
    endtask

    task automatic drive_ex(input logic rd_op, input logic wr_op, input logic [1:0] size,
                            input logic uns, input logic reg_wr, input logic [31:0] result,
                            input logic [31:0] wdata, input logic [4:0] rd);
        ex_valid = 1'b1; ex_result = result; ex_write_data = wdata; ex_rd = rd;
        ex_reg_write = reg_wr; ex_mem_read = rd_op; ex_mem_write = wr_op;
        ex_mem_size = size; ex_mem_unsigned = uns;
    endtask

    // Called just after a rising edge with the stage idle.
    task automatic run_vec(input vec_t v);
        int k, stalls;
        bit done;
        drive_ex(v.rd_op, v.wr_op, v.size, v.uns, v.reg_wr, v.result, v.wdata, v.rd);
        push_exp(v.name, v.rd, v.exp_data, v.chk_data, v.exp_we, v.exp_err, v.exp_trap);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk($sformatf("%s fwd", v.name), mem_forward, v.result);
        if (v.exp_req) begin
            chk($sformatf("%s req", v.name), 32'(dmem_req), 32'd1);
            chk($sformatf("%s addr", v.name), 32'(dmem_addr), 32'(v.exp_addr));
            chk($sformatf("%s be", v.name), 32'(dmem_be), 32'(v.exp_be));
            chk($sformatf("%s wdata", v.name), dmem_wdata, v.exp_wdata);
            chk($sformatf("%s we", v.name), 32'(dmem_we), 32'(v.wr_op));
            stalls = 0; k = 0; done = 1'b0;
            while (!done && k < 40) begin
                dmem_ack   = (k == v.ack_dly);
                dmem_rdata = v.rdata;
                #1;
                if (stall) stalls++;
                else       done = 1'b1;
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                k++;
            end
            if (!done) begin
                n_chk++; n_fail++;
                $display("FAIL %s bound: stall still %0d after %0d cycles, required release", v.name, stall, k);
            end
            chk($sformatf("%s stall_cycles", v.name), 32'(stalls), 32'(v.exp_stall));
        end else begin
            chk($sformatf("%s noreq", v.name), 32'(dmem_req), 32'd0);
            chk($sformatf("%s nostall", v.name), 32'(stall), 32'd0);
            @(posedge clk); #1;
        end
        chk($sformatf("%s req_idle", v.name), 32'(dmem_req), 32'd0);
    endtask

    always @(posedge clk) w_load <= !stall;

    always @(negedge clk) begin
        if (rst_n && w_load && wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("wb_spurious", 32'(wb_valid), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk($sformatf("%s wb_rd", mon_e.name), 32'(wb_rd), 32'(mon_e.rd));
                chk($sformatf("%s wb_we", mon_e.name), 32'(wb_reg_write), 32'(mon_e.we));
                chk($sformatf("%s bus_err", mon_e.name), 32'(bus_err), 32'(mon_e.err));
                chk($sformatf("%s trap", mon_e.name), 32'(misalign_trap), 32'(mon_e.trap));
                if (mon_e.chk_data) chk($sformatf("%s wb_data", mon_e.name), wb_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name        rd wr sz u  rw result        wdata         rd ack rdata         req addr   be       exp_wdata     st data          cd we er tr
        vecs.push_back(mk("alu",      0, 0, 2, 0, 1, 32'h0000_1234, 32'h0,        5, 0,  32'h0,        0, 10'h0,  4'b0000, 32'h0,        0, 32'h0000_1234, 1, 1, 0, 0));
        vecs.push_back(mk("alu_nowr", 0, 0, 2, 0, 0, 32'hFFFF_0001, 32'h0,        9, 0,  32'h0,        0, 10'h0,  4'b0000, 32'h0,        0, 32'hFFFF_0001, 1, 0, 0, 0));
        vecs.push_back(mk("sb",       0, 1, 0, 0, 0, 32'h0000_0103, 32'h1234_56AB, 0, 2,  32'h0,        1, 10'h40, 4'b1000, 32'hABAB_ABAB, 2, 32'h0000_0103, 1, 0, 0, 0));
        vecs.push_back(mk("lb",       1, 0, 0, 0, 1, 32'h0000_0002, 32'h0,        7, 0,  32'h0080_0000, 1, 10'h0,  4'b0100, 32'h0,        0, 32'hFFFF_FF80, 1, 1, 0, 0));
        vecs.push_back(mk("lbu",      1, 0, 0, 1, 1, 32'h0000_0002, 32'h0,        7, 0,  32'h0080_0000, 1, 10'h0,  4'b0100, 32'h0,        0, 32'h0000_0080, 1, 1, 0, 0));
        vecs.push_back(mk("lh",       1, 0, 1, 0, 1, 32'h0000_0002, 32'h0,        8, 1,  32'h8001_0000, 1, 10'h0,  4'b1100, 32'h0,        1, 32'hFFFF_8001, 1, 1, 0, 0));
        vecs.push_back(mk("lhu",      1, 0, 1, 1, 1, 32'h0000_0000, 32'h0,        10, 0, 32'h1234_F00D, 1, 10'h0,  4'b0011, 32'h0,        0, 32'h0000_F00D, 1, 1, 0, 0));
        vecs.push_back(mk("sh",       0, 1, 1, 0, 0, 32'h0000_0206, 32'h0000_BEEF, 0, 0,  32'h0,        1, 10'h81, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0000_0206, 1, 0, 0, 0));
        vecs.push_back(mk("sw",       0, 1, 2, 0, 0, 32'h0000_03FC, 32'hDEAD_BEEF, 0, 4,  32'h0,        1, 10'hFF, 4'b1111, 32'hDEAD_BEEF, 4, 32'h0000_03FC, 1, 0, 0, 0));
        vecs.push_back(mk("lw",       1, 0, 2, 0, 1, 32'h0000_0010, 32'h0,        11, 3, 32'hCAFE_F00D, 1, 10'h4,  4'b1111, 32'h0,        3, 32'hCAFE_F00D, 1, 1, 0, 0));
        vecs.push_back(mk("lw_tmo",   1, 0, 2, 0, 1, 32'h0000_0020, 32'h0,        12, 99, 32'h0,       1, 10'h8,  4'b1111, 32'h0,        15, 32'h0,        0, 0, 1, 0));
        vecs.push_back(mk("lw_after", 1, 0, 2, 0, 1, 32'h0000_0024, 32'h0,        13, 0, 32'h5A5A_0000, 1, 10'h9,  4'b1111, 32'h0,        0, 32'h5A5A_0000, 1, 1, 0, 0));
`ifdef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_mis",   1, 0, 2, 0, 1, 32'h0000_0006, 32'h0,        14, 0, 32'h1122_3344, 0, 10'h0,  4'b0000, 32'h0,        0, 32'h0,         0, 0, 0, 1));
        vecs.push_back(mk("lh_mis",   1, 0, 1, 0, 1, 32'h0000_0003, 32'h0,        15, 0, 32'hABCD_0000, 0, 10'h0,  4'b0000, 32'h0,        0, 32'h0,         0, 0, 0, 1));
`else
        vecs.push_back(mk("lw_mis",   1, 0, 2, 0, 1, 32'h0000_0006, 32'h0,        14, 0, 32'h1122_3344, 1, 10'h1,  4'b1111, 32'h0,        0, 32'h1122_3344, 1, 1, 0, 0));
        vecs.push_back(mk("lh_mis",   1, 0, 1, 0, 1, 32'h0000_0003, 32'h0,        15, 0, 32'hABCD_0000, 1, 10'h0,  4'b1100, 32'h0,        0, 32'hFFFF_ABCD, 1, 1, 0, 0));
`endif
        vecs.push_back(mk("lb_top",   1, 0, 0, 0, 1, 32'h0000_03FF, 32'h0,        31, 0, 32'h7F00_0000, 1, 10'hFF, 4'b1000, 32'h0,        0, 32'h0000_007F, 1, 1, 0, 0));

        // Reset held with a live memory op on the inputs: everything must read zero.
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        drive_ex(1, 0, 2, 0, 1, 32'h0000_0abc, 32'h1111_2222, 5'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst req", 32'(dmem_req), 32'd0);
        chk("rst we", 32'(dmem_we), 32'd0);
        chk("rst be", 32'(dmem_be), 32'd0);
        chk("rst addr", 32'(dmem_addr), 32'd0);
        chk("rst wdata", dmem_wdata, 32'd0);
        chk("rst fwd", mem_forward, 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_rd", 32'(wb_rd), 32'd0);
        chk("rst wb_we", 32'(wb_reg_write), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst trap", 32'(misalign_trap), 32'd0);
        ex_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back loads, each acked in its first ACCESS cycle.
        drive_ex(1, 0, 2, 0, 1, 32'h0000_0040, 32'h0, 5'd20);
        push_exp("b2b_a", 5'd20, 32'h0123_4567, 1, 1, 0, 0);
        @(posedge clk); #1;
        drive_ex(1, 0, 0, 1, 1, 32'h0000_0045, 32'h0, 5'd21);
        push_exp("b2b_b", 5'd21, 32'h0000_009A, 1, 1, 0, 0);
        chk("b2b req1", 32'(dmem_req), 32'd1);
        chk("b2b addr1", 32'(dmem_addr), 32'h10);
        dmem_ack = 1'b1; dmem_rdata = 32'h0123_4567;
        #1;
        chk("b2b stall1", 32'(stall), 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("b2b req2", 32'(dmem_req), 32'd1);
        chk("b2b addr2", 32'(dmem_addr), 32'h11);
        chk("b2b be2", 32'(dmem_be), 32'b0010);
        dmem_ack = 1'b1; dmem_rdata = 32'h0000_9A00;
        #1;
        chk("b2b stall2", 32'(stall), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("b2b req_idle", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;

        // A stray ack while idle must not disturb a plain ALU op.
        drive_ex(0, 0, 2, 0, 1, 32'h0000_0055, 32'h0, 5'd4);
        push_exp("stray", 5'd4, 32'h0000_0055, 1, 1, 0, 0);
        dmem_ack = 1'b1;
        #1;
        chk("stray stall0", 32'(stall), 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("stray stall1", 32'(stall), 32'd0);
        chk("stray req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;

        // Reset in the middle of an unacked access abandons it.
        drive_ex(1, 0, 2, 0, 1, 32'h0000_0030, 32'h0, 5'd3);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("rstmid req", 32'(dmem_req), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rstmid req_drop", 32'(dmem_req), 32'd0);
        chk("rstmid stall_drop", 32'(stall), 32'd0);
        chk("rstmid wb_valid", 32'(wb_valid), 32'd0);
        run_vec(vecs[0]);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
